bitserial_subtractor: RTL and testbench



---
 rtl/bitserial_pkg.sv | 16 +
 rtl/fsub_cell.sv | 20 ++
 rtl/bitserial_subtractor.sv | 129 ++++++++++++
 tb/tb_bitserial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bitserial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e    : controller states (IDLE, RUN, DONE)
//   cnt_width  : bits needed for a counter that reaches w (counts 0..w)
package bitserial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fsub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - brw (mod 2), with borrow out.
// Ports:
//   a, b      : operand bits (minuend, subtrahend)
//   brw       : borrow in
//   d         : difference bit
//   brw_next  : borrow out
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic brw,
  output logic d,
  output logic brw_next
);

  always_comb begin
    d        = a ^ b ^ brw;
    brw_next = (~a & b) | (~a & brw) | (b & brw);
  end

endmodule

// File: rtl/bitserial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^W, bout = borrow,
// processed one bit per clock LSB first through a single full-subtractor cell.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow-in
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   diff, bout          : result and borrow-out, held until the next result
module bitserial_subtractor
  import bitserial_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          brw_q, brw_d;
  logic          bout_q, bout_d;

  logic          cell_d;
  logic          cell_brw;
  logic          accept;
  logic          last_step;
  logic [W:0]    res_ext;

  fsub_cell u_cell (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .brw      (brw_q),
    .d        (cell_d),
    .brw_next (cell_brw)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

  assign accept    = in_valid & in_ready;
  assign last_step = (state_q == RUN) && (cnt_q == LAST_BIT);
  // New bit enters at the MSB; taking [W:1] also covers W=1 cleanly.
  assign res_ext   = {cell_d, res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working result lives in res_q so the visible diff only changes on completion.
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    brw_d  = brw_q;
    res_d  = res_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      brw_d  = bin;
    end else if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      brw_d  = cell_brw;
      res_d  = res_ext[W:1];
    end
    if (last_step) begin
      diff_d = res_ext[W:1];
      bout_d = cell_brw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    brw_q  <= brw_d;
    res_q  <= res_d;
  end

endmodule

// File: tb/tb_bitserial_subtractor.sv
module tb_bitserial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // W=3 instance
  logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [2:0] a, b, diff;

  bitserial_subtractor #(.W(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  // W=1 instance
  logic       iv1, ir1, ov1, bin1, bout1;
  logic [0:0] a1, b1, diff1;

  bitserial_subtractor #(.W(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(1'b1),
    .diff(diff1), .bout(bout1)
  );

  // W=8 instance
  logic       iv8, ir8, ov8, bin8, bout8;
  logic [7:0] a8, b8, diff8;

  bitserial_subtractor #(.W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(1'b1),
    .diff(diff8), .bout(bout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete W=3 transaction with out_ready held high.
  task automatic run3(input string tag, input logic [2:0] xa, input logic [2:0] xb,
                      input logic xbin, input logic [2:0] ediff, input logic ebout);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bout"}, bout, ebout);
    @(negedge clk);
    check({tag, "_ov_after"}, out_valid, 0);
    check({tag, "_rdy_after"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int q[$];
    int idx, got, guard, e;
    logic [3:0] exp4;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);

    run3("sub_5_3", 3'd5, 3'd3, 1'b0, 3'd2, 1'b0);
    run3("sub_3_5", 3'd3, 3'd5, 1'b0, 3'd6, 1'b1);
    run3("sub_0_0_b", 3'd0, 3'd0, 1'b1, 3'd7, 1'b1);
    run3("sub_7_7", 3'd7, 3'd7, 1'b0, 3'd0, 1'b0);

    // Backpressure: 6 - 1 - 1 = 4, held while out_ready is low.
    @(negedge clk);
    a = 3'd6; b = 3'd1; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_diff", diff, 4);
      check("bp_bout", bout, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      a = 3'd1; b = 3'd2; bin = 1'b0; in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ov", out_valid, 0);
    check("bp_release_rdy", in_ready, 1);
    check("bp_release_diff", diff, 4);

    // Reset on the second RUN cycle discards the operation.
    a = 3'd5; b = 3'd1; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_diff", diff, 0);
    check("mrst_bout", bout, 0);
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) lat++;
      @(negedge clk);
    end
    check("mrst_no_result", lat, 0);
    run3("mrst_fresh", 3'd4, 3'd1, 1'b0, 3'd3, 1'b0);

    // Exhaustive back-to-back with random out_ready; results must come in order.
    idx = 0; got = 0; guard = 0;
    while (got < 128 && guard < 5000) begin
      @(negedge clk);
      guard++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("exh_extra_result", 1, 0);
        end else begin
          e = q.pop_front();
          exp4 = 4'(e & 7) - 4'((e >> 3) & 7) - 4'((e >> 6) & 1);
          check("exh_result", {bout, diff}, exp4);
          check("exh_identity", 32'(diff) + 32'((e >> 3) & 7) + 32'((e >> 6) & 1),
                32'(e & 7) + 32'(bout) * 8);
          got++;
        end
      end
      if (idx < 128) begin
        a = 3'(idx); b = 3'(idx >> 3); bin = 1'(idx >> 6); in_valid = 1'b1;
        if (in_ready) begin
          q.push_back(idx);
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("exh_count", got, 128);
    check("exh_accepts", idx, 128);

    // W=1: 0 - 1 = 1 with borrow, one RUN cycle.
    @(negedge clk);
    check("w1_in_ready", ir1, 1);
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w1_latency", lat, 1);
    check("w1_diff", diff1, 1);
    check("w1_bout", bout1, 1);

    // W=8: 0 - 1 = 255 with borrow.
    @(negedge clk);
    check("w8_in_ready", ir8, 1);
    a8 = 8'd0; b8 = 8'd1; bin8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w8_latency", lat, 8);
    check("w8_diff", diff8, 255);
    check("w8_bout", bout8, 1);
    @(negedge clk);
    check("w8_rdy_after", ir8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
